tpu_job_sequencer: RTL and testbench
====================================

Name: tpu_job_sequencer

Overview:
- Sits directly upstream of the TPU memory-mapped slave (64-bit dataIn/dataOut, 16-bit addr, r_w) and acts as its only bus master.
- Converts one "job" into the exact bus transaction sequence the TPU expects:
  - consume 8 A rows and 8 B rows from an input word stream;
  - optionally zero the C accumulators;
  - fire MatMul and wait out the array latency;
  - read back 16 C words into an output word stream.
- Replaces host-driven per-address MMIO pokes with a streaming job interface.

Parameters:
- DATAW, 64, stream and TPU data width.
- ADDRW, 16, TPU address width.
- DIM, 8, matrix dimension; A and B rows per job.
- C_WORDS, 16, C words per job (DIM rows x 2 halves).
- MATMUL_WAIT, 24, idle cycles after the MatMul write before the first C read; must be at least 3*DIM-2.
- A_BASE, 16'h0100, address of A row 0; row k is at A_BASE+8k.
- B_BASE, 16'h0200, address of B row 0; row k is at B_BASE+8k.
- C_BASE, 16'h0300, address of C word 0; word k is at C_BASE+8k (even k = low half of row k/2, odd k = high half).
- MM_ADDR, 16'h0400, MatMul trigger address.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle job request; sampled only in IDLE.
- clear_c  in  1  sampled with start; 1 = write 16 zero C words before MatMul.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the last C word handshake.
- start_err  out  1  one-cycle pulse when start=1 while busy.
- in_valid  in  1  input word valid.
- in_ready  out  1  input word accepted when in_valid&in_ready.
- in_data  in  DATAW  A rows (8 words), then B rows (8 words).
- out_valid  out  1  C word valid.
- out_ready  in  1  downstream accepts C word.
- out_data  out  DATAW  C word.
- tpu_r_w  out  1  1 = write, 0 = read.
- tpu_addr  out  ADDRW  TPU address.
- tpu_dataIn  out  DATAW  TPU write data.
- tpu_dataOut  in  DATAW  TPU read data; combinational from tpu_addr.

Behaviour:
- Reset (rst=1 at a clk edge): state IDLE; all outputs 0, including tpu_addr and tpu_dataIn; counters 0.
  - Reset mid-job abandons the job with no further bus writes.
  - A pending out_valid word is dropped.
- All outputs are registered. A bus cycle is the single clk cycle in which tpu_r_w/tpu_addr/tpu_dataIn hold a value.
- Idle bus: tpu_r_w=0, tpu_addr=0, tpu_dataIn=0.
- IDLE:
  - start=1 -> LOAD_A; clear_c is latched and the word counter is cleared.
- LOAD_A, then LOAD_B:
  - in_ready=1 throughout both states.
  - Each handshake at word index k produces a write bus cycle on the next cycle: tpu_r_w=1, addr=A_BASE+8k (or B_BASE+8k), dataIn=in_data.
  - The 8th A word moves to LOAD_B with no ready bubble.
  - After the 8th B word: go to CLEAR_C if clear_c is latched, else MM; in_ready drops the next cycle.
  - in_valid=0 stalls with an idle bus.
- CLEAR_C:
  - 16 consecutive write cycles, dataIn=0, addr=C_BASE+8k, k=0..15 ascending.
- MM:
  - One write cycle: addr=MM_ADDR, dataIn=0.
  - Then WAIT for exactly MATMUL_WAIT cycles with an idle bus.
- READ_C, per word k=0..15:
  - ISSUE: tpu_r_w=0, tpu_addr=C_BASE+8k.
  - CAPTURE: same address still held; out_data <= tpu_dataOut; out_valid set.
  - HOLD: out_valid=1 and out_data stable until out_ready. On the handshake, out_valid clears next cycle and k increments.
  - Throughput is at most one word per 3 cycles. No new read is issued while out_valid=1.
- DONE:
  - done=1 for one cycle, busy=0 from the following cycle, state IDLE.
  - A start in the DONE cycle is treated as start-while-busy.
- Errors and ignored inputs:
  - start while busy: ignored; start_err pulses; the job is unaffected.
  - in_valid outside LOAD_A/LOAD_B: ignored (in_ready=0).
  - out_ready with out_valid=0: no effect.
- Counters:
  - Word counter is 4 bits; wrap 15->0 only at the end of READ_C/CLEAR_C.
  - Wait counter is $clog2(MATMUL_WAIT+1) bits.

Test Plan:
- Reset, then idle 5 cycles -> busy=0, out_valid=0, tpu_r_w=0, tpu_addr=0 every cycle.
- start with clear_c=0; in_data=k+1 on an always-valid stream; out_ready=1 -> 16 write cycles: A addrs 0x0100..0x0138 with data 1..8, B addrs 0x0200..0x0238 with data 9..16. Then one write to 0x0400, exactly 24 idle cycles, reads of 0x0300..0x0378 ascending. out_data equals the model TPU value per address; one done pulse.
- Same job with clear_c=1 -> 16 zero-data writes to 0x0300..0x0378 between the last B write and the 0x0400 write.
- in_valid toggling 1/0 and out_ready held 0 for 10 cycles on word 3 -> write addresses stay contiguous. out_data is stable while stalled, and the 0x0318 read is not issued until the word-3 handshake.
- start pulsed during LOAD_B and during DONE -> start_err=1 each time; the job completes with exactly 16 output words; no second job begins.
- rst during WAIT (cycle 10) -> next cycle busy=0 and out_valid=0; no write to 0x03xx occurs; a fresh job afterwards completes normally.

Source files
------------

// File: rtl/tpu_job_sequencer.sv
// Streaming job front-end for the TPU slave: turns 16 input rows into the
// A/B write burst, optional C clear, MatMul trigger, and a paced C read-back.
module tpu_job_sequencer #(
    parameter int DATAW       = 64,
    parameter int ADDRW       = 16,
    parameter int DIM         = 8,
    parameter int C_WORDS     = 16,
    parameter int MATMUL_WAIT = 24,
    parameter logic [ADDRW-1:0] A_BASE  = 16'h0100,
    parameter logic [ADDRW-1:0] B_BASE  = 16'h0200,
    parameter logic [ADDRW-1:0] C_BASE  = 16'h0300,
    parameter logic [ADDRW-1:0] MM_ADDR = 16'h0400
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             clear_c,
    output logic             busy,
    output logic             done,
    output logic             start_err,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DATAW-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DATAW-1:0] out_data,
    output logic             tpu_r_w,
    output logic [ADDRW-1:0] tpu_addr,
    output logic [DATAW-1:0] tpu_dataIn,
    input  logic [DATAW-1:0] tpu_dataOut
);

    // state     | meaning
    // IDLE      | waiting for start
    // LOAD_A    | streaming A rows into the TPU
    // LOAD_B    | streaming B rows into the TPU
    // CLEAR_C   | zeroing the C accumulators
    // MM        | issuing the MatMul trigger write
    // WAIT      | letting the systolic array drain
    // ISSUE     | C read address on the bus
    // CAPTURE   | C read data sampled into out_data
    // HOLD      | C word offered downstream until accepted
    // DONE      | one-cycle completion pulse
    typedef enum logic [3:0] {
        S_IDLE, S_LOAD_A, S_LOAD_B, S_CLEAR_C, S_MM,
        S_WAIT, S_ISSUE, S_CAPTURE, S_HOLD, S_DONE
    } state_t;

    localparam int WCW = $clog2(MATMUL_WAIT + 1);
    localparam logic [3:0] DIM_LAST = 4'(DIM - 1);
    localparam logic [3:0] C_LAST   = 4'(C_WORDS - 1);

    state_t         state;
    logic [3:0]     word_cnt;
    logic [WCW-1:0] wait_cnt;
    logic           clr_lat;

    function automatic logic [ADDRW-1:0] word_addr(input logic [ADDRW-1:0] base,
                                                   input logic [3:0] idx);
        return base + ADDRW'({idx, 3'b000});
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            word_cnt   <= '0;
            wait_cnt   <= '0;
            clr_lat    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            start_err  <= 1'b0;
            in_ready   <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            tpu_r_w    <= 1'b0;
            tpu_addr   <= '0;
            tpu_dataIn <= '0;
        end else begin
            // bus returns to idle unless a state below drives a cycle
            tpu_r_w    <= 1'b0;
            tpu_addr   <= '0;
            tpu_dataIn <= '0;
            done       <= 1'b0;
            start_err  <= start && (state != S_IDLE);

            case (state)
                S_IDLE: begin
                    if (start) begin
                        state    <= S_LOAD_A;
                        clr_lat  <= clear_c;
                        word_cnt <= '0;
                        busy     <= 1'b1;
                        in_ready <= 1'b1;
                    end
                end
                S_LOAD_A, S_LOAD_B: begin
                    if (in_valid) begin
                        tpu_r_w    <= 1'b1;
                        tpu_addr   <= word_addr((state == S_LOAD_A) ? A_BASE : B_BASE, word_cnt);
                        tpu_dataIn <= in_data;
                        if (word_cnt == DIM_LAST) begin
                            word_cnt <= '0;
                            if (state == S_LOAD_A) begin
                                state <= S_LOAD_B;
                            end else begin
                                in_ready <= 1'b0;
                                state    <= clr_lat ? S_CLEAR_C : S_MM;
                            end
                        end else begin
                            word_cnt <= word_cnt + 4'd1;
                        end
                    end
                end
                S_CLEAR_C: begin
                    tpu_r_w  <= 1'b1;
                    tpu_addr <= word_addr(C_BASE, word_cnt);
                    word_cnt <= word_cnt + 4'd1;
                    if (word_cnt == C_LAST) state <= S_MM;
                end
                S_MM: begin
                    tpu_r_w  <= 1'b1;
                    tpu_addr <= MM_ADDR;
                    wait_cnt <= WCW'(MATMUL_WAIT);
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        tpu_addr <= word_addr(C_BASE, word_cnt);
                        state    <= S_ISSUE;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                S_ISSUE: begin
                    tpu_addr <= tpu_addr;
                    state    <= S_CAPTURE;
                end
                S_CAPTURE: begin
                    out_data  <= tpu_dataOut;
                    out_valid <= 1'b1;
                    state     <= S_HOLD;
                end
                S_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        word_cnt  <= word_cnt + 4'd1;
                        if (word_cnt == C_LAST) begin
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            tpu_addr <= word_addr(C_BASE, word_cnt + 4'd1);
                            state    <= S_ISSUE;
                        end
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tpu_job_sequencer.sv
// Randomized job bench for tpu_job_sequencer with a transaction-level model
// of the expected bus sequence and read-back words.
module tb_tpu_job_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, clear_c, in_valid, out_ready;
    logic [63:0] in_data;
    logic        busy, done, start_err, in_ready, out_valid, tpu_r_w;
    logic [63:0] out_data, tpu_dataIn, tpu_dataOut;
    logic [15:0] tpu_addr;
    logic [31:0] salt;

    always #5 clk = ~clk;

    tpu_job_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .clear_c(clear_c),
        .busy(busy), .done(done), .start_err(start_err),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .tpu_r_w(tpu_r_w), .tpu_addr(tpu_addr), .tpu_dataIn(tpu_dataIn),
        .tpu_dataOut(tpu_dataOut)
    );

    // TPU slave model: read data is a salted function of the address
    assign tpu_dataOut = {salt ^ {16'h0, tpu_addr}, 16'hC0DE, tpu_addr};

    function automatic logic [63:0] tpu_val(input logic [15:0] a);
        return {salt ^ {16'h0, a}, 16'hC0DE, a};
    endfunction

    typedef struct { logic [15:0] a; logic [63:0] d; int c; } bus_t;

    bus_t        wq[$];
    logic [15:0] rq_a[$];
    int          rq_c[$];
    logic [63:0] oq[$];
    int          hs_c[$];
    int cyc, in_hs, done_cnt, serr_cnt, stab_err, rd_while_valid, idle_dirty, mm_cyc;
    logic        prev_hold, prev_rd;
    logic [63:0] prev_data;
    logic [15:0] prev_a;
    logic [63:0] words [16];

    int n_cmp = 0;
    int n_bad = 0;

    always @(negedge clk) begin
        cyc++;
        if (tpu_r_w) begin
            wq.push_back('{a: tpu_addr, d: tpu_dataIn, c: cyc});
            if (tpu_addr == 16'h0400) mm_cyc = cyc;
        end else if (tpu_addr != 16'h0) begin
            if (!(prev_rd && prev_a == tpu_addr)) begin
                rq_a.push_back(tpu_addr);
                rq_c.push_back(cyc);
            end
        end else if (tpu_dataIn != 64'h0) begin
            idle_dirty++;
        end
        prev_rd = !tpu_r_w && tpu_addr != 16'h0;
        prev_a  = tpu_addr;
        if (out_valid && !tpu_r_w && tpu_addr != 16'h0) rd_while_valid++;
        if (prev_hold && !(out_valid && out_data == prev_data)) stab_err++;
        prev_hold = out_valid && !out_ready;
        prev_data = out_data;
        if (out_valid && out_ready) begin
            oq.push_back(out_data);
            hs_c.push_back(cyc);
        end
        if (in_valid && in_ready) in_hs++;
        if (done) done_cnt++;
        if (start_err) serr_cnt++;
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_mon();
        wq.delete(); rq_a.delete(); rq_c.delete(); oq.delete(); hs_c.delete();
        in_hs = 0; done_cnt = 0; serr_cnt = 0; stab_err = 0;
        rd_while_valid = 0; idle_dirty = 0; mm_cyc = 0;
    endtask

    task automatic run_job(input bit clr, input bit seq, input int vmode, input int rmode,
                           input bit bad, input bit rst_wait);
        int  stall = 0;
        int  post = 0;
        bit  s1 = 0;
        bit  s2 = 0;
        clear_mon();
        salt = $urandom;
        for (int k = 0; k < 16; k++) words[k] = seq ? 64'(k + 1) : {$urandom, $urandom};
        start = 1'b1; clear_c = clr; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; clear_c = !clr;
        for (int t = 0; t < 3000; t++) begin
            case (vmode)
                0:       in_valid = 1'b1;
                1:       in_valid = (t % 2 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_data = (in_hs < 16) ? words[in_hs] : {$urandom, $urandom};
            case (rmode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (oq.size() == 2 && out_valid && stall < 10) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            start = 1'b0;
            if (bad && !s1 && in_hs >= 10) begin
                start = 1'b1; s1 = 1;
            end else if (bad && !s2 && done) begin
                start = 1'b1; s2 = 1;
            end
            if (rst_wait && mm_cyc != 0 && cyc - mm_cyc == 10) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                break;
            end
            @(posedge clk); #1;
            if (done_cnt > 0) post++;
            if (post >= 8) break;
        end
        in_valid = 1'b0; out_ready = 1'b0; start = 1'b0; clear_c = 1'b0;
    endtask

    task automatic check_job(input string name, input bit clr, input int exp_serr);
        bus_t ex[$];
        for (int k = 0; k < 8; k++) ex.push_back('{a: 16'h0100 + 16'(8 * k), d: words[k], c: 0});
        for (int k = 0; k < 8; k++) ex.push_back('{a: 16'h0200 + 16'(8 * k), d: words[8 + k], c: 0});
        if (clr) for (int k = 0; k < 16; k++) ex.push_back('{a: 16'h0300 + 16'(8 * k), d: 64'h0, c: 0});
        ex.push_back('{a: 16'h0400, d: 64'h0, c: 0});

        chk({name, " n_writes"}, wq.size(), ex.size());
        for (int i = 0; i < ex.size() && i < wq.size(); i++)
            chk($sformatf("%s write[%0d] addr/data", name, i), {wq[i].a, wq[i].d}, {ex[i].a, ex[i].d});
        if (clr && wq.size() == ex.size())
            chk({name, " clear_contiguous"}, wq[31].c - wq[16].c, 15);
        chk({name, " n_reads"}, rq_a.size(), 16);
        for (int k = 0; k < 16 && k < rq_a.size(); k++)
            chk($sformatf("%s read_addr[%0d]", name, k), rq_a[k], 16'h0300 + 16'(8 * k));
        if (rq_c.size() > 0 && wq.size() > 0)
            chk({name, " matmul_idle_gap"}, rq_c[0] - wq[wq.size() - 1].c - 1, 24);
        chk({name, " n_out"}, oq.size(), 16);
        for (int k = 0; k < 16 && k < oq.size(); k++)
            chk($sformatf("%s out_data[%0d]", name, k), oq[k], tpu_val(16'h0300 + 16'(8 * k)));
        for (int k = 0; k < 15 && k + 1 < rq_c.size() && k < hs_c.size(); k++)
            chk($sformatf("%s read_after_hs[%0d]", name, k), rq_c[k + 1] > hs_c[k], 1);
        chk({name, " in_handshakes"}, in_hs, 16);
        chk({name, " out_stable"}, stab_err, 0);
        chk({name, " read_while_valid"}, rd_while_valid, 0);
        chk({name, " idle_bus_data"}, idle_dirty, 0);
        chk({name, " done_pulses"}, done_cnt, 1);
        chk({name, " start_err_pulses"}, serr_cnt, exp_serr);
        chk({name, " busy_after"}, busy, 0);
        chk({name, " in_ready_after"}, in_ready, 0);
    endtask

    initial begin
        int n03;
        rst = 1'b1; start = 1'b0; clear_c = 1'b0; in_valid = 1'b0;
        in_data = 64'h0; out_ready = 1'b0; salt = 32'h1234_5678;
        prev_hold = 1'b0; prev_rd = 1'b0; prev_data = 64'h0; prev_a = 16'h0;
        clear_mon();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle busy", busy, 0);
            chk("idle out_valid", out_valid, 0);
            chk("idle tpu_r_w", tpu_r_w, 0);
            chk("idle tpu_addr", tpu_addr, 0);
        end
        @(posedge clk); #1;

        run_job(0, 1, 0, 0, 0, 0); check_job("plain", 0, 0);
        run_job(1, 1, 0, 0, 0, 0); check_job("clear_c", 1, 0);
        run_job(0, 0, 1, 2, 0, 0); check_job("stall", 0, 0);
        run_job(0, 0, 0, 0, 1, 0); check_job("bad_start", 0, 2);

        run_job(0, 0, 0, 0, 0, 1);
        chk("rst busy", busy, 0);
        chk("rst out_valid", out_valid, 0);
        repeat (30) @(posedge clk);
        #1;
        n03 = 0;
        foreach (wq[i]) if (wq[i].a[15:8] == 8'h03) n03++;
        chk("rst no C writes", n03, 0);
        chk("rst writes", wq.size(), 17);
        chk("rst no reads", rq_a.size(), 0);
        chk("rst no done", done_cnt, 0);

        run_job(0, 0, 2, 1, 0, 0); check_job("after_rst", 0, 0);
        for (int j = 0; j < 4; j++) begin
            bit c = 1'($urandom_range(0, 1));
            run_job(c, 0, 2, 1, 0, 0);
            check_job($sformatf("random%0d", j), c, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
